// File: rtl/data_ram_pkg.sv
// Shared constants, payload types and helpers for the data-memory responder.
package data_ram_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;

  // Init-sweep state machine encoding
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // MMIO byte offsets from the window base
  localparam logic [31:0] OFF_CNT     = 32'h0000_0000;
  localparam logic [31:0] OFF_SCRATCH = 32'h0000_0004;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_0008;

  // STATUS register bit positions
  localparam int unsigned STAT_ERR       = 0;
  localparam int unsigned STAT_INIT_DONE = 1;

  // Byte-lane write payload into the storage array
  typedef struct packed {
    logic [LANES-1:0]  sel;
    logic [WORD_W-1:0] data;
  } lane_wr_t;

  // Replace only the byte lanes whose select bit is set
  function automatic logic [WORD_W-1:0] merge_lanes(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [LANES-1:0]  sel
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(LANES); i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word storage: one asynchronous read port, one synchronous byte-lane write port.
module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WORD_W-1:0]     rd_data_c,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  lane_wr_t              wr
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  assign rd_data_c = mem[rd_addr];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= merge_lanes(mem[wr_addr], wr.data, wr.sel);
  end

endmodule

// File: rtl/data_ram.sv
// CPU data-memory responder: combinational reads, byte-lane writes, MMIO window,
// sticky unmapped-access error and a post-reset zero sweep of the array.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  input  logic        write_enable,
  input  logic [31:0] write_address,
  input  logic [3:0]  write_select,
  input  logic [31:0] write_data,
  output logic        init_done,
  output logic        error
);

  localparam int unsigned AW = DEPTH_LOG2;
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
  localparam logic [29:0] CNT_WORD     = 30'((MMIO_BASE + OFF_CNT) >> 2);
  localparam logic [29:0] SCRATCH_WORD = 30'((MMIO_BASE + OFF_SCRATCH) >> 2);
  localparam logic [29:0] STATUS_WORD  = 30'((MMIO_BASE + OFF_STATUS) >> 2);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          init_done_q, init_done_d;
  logic          error_q;
  logic [31:0]   cnt_q;
  logic [31:0]   scratch_q;
  logic          ready_c;

  logic [29:0] rd_word_c, wr_word_c;
  logic        rd_is_ram_c, rd_is_cnt_c, rd_is_scratch_c, rd_is_status_c, rd_unmapped_c;
  logic        wr_is_ram_c, wr_is_cnt_c, wr_is_scratch_c, wr_is_status_c, wr_unmapped_c;
  logic        wr_any_lane_c;
  logic        err_set_c, err_clr_c;
  logic [31:0] status_c;

  logic [AW-1:0] arr_wr_addr_c;
  logic          arr_wr_en_c;
  lane_wr_t      arr_wr_c;
  logic [31:0]   arr_rd_data_c;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{read_address[1:0], write_address[1:0]};

  // Address decode for both ports
  assign rd_word_c       = read_address[31:2];
  assign wr_word_c       = write_address[31:2];
  assign rd_is_ram_c     = (read_address[31:AW+2] == '0);
  assign rd_is_cnt_c     = (rd_word_c == CNT_WORD);
  assign rd_is_scratch_c = (rd_word_c == SCRATCH_WORD);
  assign rd_is_status_c  = (rd_word_c == STATUS_WORD);
  assign rd_unmapped_c   = !(rd_is_ram_c || rd_is_cnt_c || rd_is_scratch_c || rd_is_status_c);
  assign wr_is_ram_c     = (write_address[31:AW+2] == '0);
  assign wr_is_cnt_c     = (wr_word_c == CNT_WORD);
  assign wr_is_scratch_c = (wr_word_c == SCRATCH_WORD);
  assign wr_is_status_c  = (wr_word_c == STATUS_WORD);
  assign wr_unmapped_c   = !(wr_is_ram_c || wr_is_cnt_c || wr_is_scratch_c || wr_is_status_c);
  assign wr_any_lane_c   = |write_select;

  assign ready_c = (state_q == ST_READY);

  // Set takes priority over clear; concurrent unmapped read and write set once
  assign err_set_c = ready_c &&
                     ((read_enable && rd_unmapped_c) ||
                      (write_enable && wr_any_lane_c && wr_unmapped_c));
  assign err_clr_c = ready_c && write_enable && wr_is_status_c &&
                     write_select[0] && write_data[STAT_ERR];

  // Sweep owns the array write port until READY
  always_comb begin
    arr_wr_en_c   = 1'b0;
    arr_wr_addr_c = idx_q;
    arr_wr_c.sel  = '1;
    arr_wr_c.data = '0;
    if (!ready_c) begin
      arr_wr_en_c = 1'b1;
    end else begin
      arr_wr_en_c   = write_enable && wr_is_ram_c && wr_any_lane_c;
      arr_wr_addr_c = write_address[AW+1:2];
      arr_wr_c.sel  = write_select;
      arr_wr_c.data = write_data;
    end
  end

  data_ram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clock    (clock),
    .rd_addr  (read_address[AW+1:2]),
    .rd_data_c(arr_rd_data_c),
    .wr_en    (arr_wr_en_c),
    .wr_addr  (arr_wr_addr_c),
    .wr       (arr_wr_c)
  );

  always_comb begin
    status_c                 = '0;
    status_c[STAT_ERR]       = error_q;
    status_c[STAT_INIT_DONE] = init_done_q;
  end

  // Combinational read mux; nothing is visible during the sweep
  always_comb begin
    read_data = '0;
    if (read_enable && ready_c) begin
      if (rd_is_ram_c)          read_data = arr_rd_data_c;
      else if (rd_is_cnt_c)     read_data = cnt_q;
      else if (rd_is_scratch_c) read_data = scratch_q;
      else if (rd_is_status_c)  read_data = status_c;
    end
  end

  // Init sweep next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  // MMIO registers and sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      scratch_q <= '0;
      error_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (ready_c && write_enable && wr_is_scratch_c) begin
        scratch_q <= merge_lanes(scratch_q, write_data, write_select);
      end
      if (err_set_c)      error_q <= 1'b1;
      else if (err_clr_c) error_q <= 1'b0;
    end
  end

  assign init_done = init_done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram with DEPTH_LOG2=4 (16-word array).
module tb_data_ram;

  localparam logic [31:0] A_CNT     = 32'hFFFF_FF00;
  localparam logic [31:0] A_SCRATCH = 32'hFFFF_FF04;
  localparam logic [31:0] A_STATUS  = 32'hFFFF_FF08;
  localparam logic [31:0] A_UNMAP   = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_enable;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        write_enable;
  logic [31:0] write_address;
  logic [3:0]  write_select;
  logic [31:0] write_data;
  logic        init_done;
  logic        error;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] rdata;
  logic [31:0] c0;

  data_ram #(
    .DEPTH_LOG2(4),
    .MMIO_BASE (32'hFFFF_FF00)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .read_enable  (read_enable),
    .read_address (read_address),
    .read_data    (read_data),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_select (write_select),
    .write_data   (write_data),
    .init_done    (init_done),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access cycle, entered at posedge+1; rdata holds the pre-edge read result
  task automatic cyc(input logic re, input logic [31:0] ra, input logic we,
                     input logic [31:0] wa, input logic [3:0] ws, input logic [31:0] wd);
    read_enable   = re;
    read_address  = ra;
    write_enable  = we;
    write_address = wa;
    write_select  = ws;
    write_data    = wd;
    #2;
    rdata = read_data;
    @(posedge clock);
    #1;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    write_select = 4'h0;
  endtask

  task automatic sweep_check(input string tag);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      #1;
      chk_eq(tag, 32'(init_done), (k == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset         = 1'b0;
    read_enable   = 1'b0;
    read_address  = '0;
    write_enable  = 1'b0;
    write_address = '0;
    write_select  = '0;
    write_data    = '0;
    dut.u_array.mem[3] <= 32'hDEADBEEF;

    repeat (2) @(posedge clock);
    #1;
    chk_eq("rst_init_done", 32'(init_done), 32'd0);
    chk_eq("rst_error", 32'(error), 32'd0);
    read_enable  = 1'b1;
    read_address = 32'h0000_000C;
    #1;
    chk_eq("rst_rdata", read_data, 32'd0);

    // Sweep: init_done rises on the 16th edge after release; word 3 is cleared
    reset = 1'b1;
    sweep_check("init_done_sweep");
    #1;
    chk_eq("sweep_cleared_w3", read_data, 32'd0);
    read_enable = 1'b0;
    #1;
    chk_eq("rd_disabled", read_data, 32'd0);
    @(posedge clock);
    #1;

    // Byte-lane merge
    cyc(0, 0, 1, 32'h08, 4'b1111, 32'hAABBCCDD);
    cyc(0, 0, 1, 32'h08, 4'b0010, 32'h00001100);
    cyc(1, 32'h08, 0, 0, 4'b0000, 0);
    chk_eq("lane_merge", rdata, 32'hAABB11DD);
    cyc(0, 0, 1, 32'h08, 4'b0000, 32'hFFFFFFFF);
    cyc(1, 32'h08, 0, 0, 4'b0000, 0);
    chk_eq("sel_zero_nochange", rdata, 32'hAABB11DD);
    cyc(0, 32'h08, 0, 0, 4'b0000, 0);
    chk_eq("rd_en_low_zero", rdata, 32'd0);

    // Counter delta and wrap
    cyc(1, A_CNT, 0, 0, 0, 0);
    c0 = rdata;
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, A_CNT, 0, 0, 0, 0);
    chk_eq("cnt_delta5", rdata - c0, 32'd5);

    force dut.cnt_q = 32'hFFFF_FFFF;
    read_enable  = 1'b1;
    read_address = A_CNT;
    #1;
    chk_eq("cnt_forced", read_data, 32'hFFFF_FFFF);
    release dut.cnt_q;
    @(posedge clock);
    #1;
    cyc(1, A_CNT, 1, A_CNT, 4'b1111, 32'h12345678);
    chk_eq("cnt_wrap", rdata, 32'd0);
    cyc(1, A_CNT, 0, 0, 0, 0);
    chk_eq("cnt_write_ignored", rdata, 32'd1);
    chk_eq("cnt_write_no_err", 32'(error), 32'd0);

    // Unmapped access and sticky error
    cyc(0, 0, 1, A_UNMAP, 4'b0001, 32'hFF);
    chk_eq("unmap_wr_err", 32'(error), 32'd1);
    cyc(1, A_STATUS, 0, 0, 0, 0);
    chk_eq("status_read", rdata, 32'h3);
    cyc(0, 0, 1, A_STATUS, 4'b0001, 32'h1);
    chk_eq("err_clear", 32'(error), 32'd0);
    cyc(1, A_UNMAP, 1, A_STATUS, 4'b0001, 32'h1);
    chk_eq("unmap_rd_zero", rdata, 32'd0);
    chk_eq("set_beats_clear", 32'(error), 32'd1);
    cyc(0, 0, 1, A_STATUS, 4'b0001, 32'h1);
    chk_eq("err_clear2", 32'(error), 32'd0);
    cyc(0, 0, 1, A_UNMAP, 4'b0000, 32'hFF);
    chk_eq("unmap_sel0_no_err", 32'(error), 32'd0);

    // Scratch lane writes
    cyc(0, 0, 1, A_SCRATCH, 4'b1111, 32'h01234567);
    cyc(0, 0, 1, A_SCRATCH, 4'b1100, 32'hABCD0000);
    cyc(1, A_SCRATCH, 0, 0, 0, 0);
    chk_eq("scratch_merge", rdata, 32'hABCD4567);

    // Same-word read and write in one cycle
    cyc(0, 0, 1, 32'h10, 4'b1111, 32'h11111111);
    cyc(1, 32'h10, 1, 32'h10, 4'b1111, 32'h22222222);
    chk_eq("rw_same_old", rdata, 32'h11111111);
    cyc(1, 32'h10, 0, 0, 0, 0);
    chk_eq("rw_same_new", rdata, 32'h22222222);

    // Reset mid-sweep; port writes during INIT are dropped
    cyc(0, 0, 1, A_UNMAP, 4'b0001, 32'h1);
    chk_eq("pre_reset_err", 32'(error), 32'd1);
    reset = 1'b0;
    #1;
    chk_eq("async_rst_err", 32'(error), 32'd0);
    chk_eq("async_rst_done", 32'(init_done), 32'd0);
    @(negedge clock);
    reset         = 1'b1;
    write_enable  = 1'b1;
    write_address = 32'h20;
    write_select  = 4'b1111;
    write_data    = 32'hCAFEF00D;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    sweep_check("init_done_restart");
    write_enable = 1'b0;
    write_select = 4'b0000;
    cyc(1, 32'h20, 0, 0, 0, 0);
    chk_eq("init_write_dropped", rdata, 32'd0);
    cyc(1, 32'h08, 0, 0, 0, 0);
    chk_eq("resweep_cleared", rdata, 32'd0);
    chk_eq("post_restart_err", 32'(error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
